dual_slope_counter: RTL

BCD time-base and result counter for the dual-slope converter. It counts clock cycles while the control FSM holds the count enable (`en_0`). It produces the full-scale carry `en_3` that ends the fixed integration phase (`ch_vm`). It then measures the de-integration phase (`ch_ref`) and latches the 3-digit BCD result when the FSM switches to zeroing (`ch_zr`). It sits directly beside the control FSM: `en_0` and `ch` come in, `en_3` goes back out.

---
 rtl/dual_slope_counter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dual_slope_counter.sv
// BCD time-base / result counter for the dual-slope converter.
// Counts enabled clocks, flags full scale, latches the conversion.
module dual_slope_counter #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en_0,
  input  logic [2:0]            ch,
  output logic                  en_3,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   result,
  output logic                  valid,
  output logic                  ovf
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    INTEG,
    DEINT,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   result_q, result_d;
  logic           en_3_q, en_3_d;
  logic           valid_q, valid_d;
  logic           ovf_q, ovf_d;

  logic [W-1:0]   count_inc;
  logic [W-1:0]   count_nxt;
  logic           all_nine;
  logic           inc_en;
  logic           wrap;
  logic           latch;
  logic [3:0]     dig;
  logic           carry;

  // BCD +1 ripple; the final carry means the count was all nines
  always_comb begin
    count_inc = '0;
    carry     = 1'b1;
    dig       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (carry) begin
        if (dig == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end else begin
        count_inc[4*i +: 4] = dig;
      end
    end
    all_nine = carry;
  end

  // qualifiers shared by the next-state logic
  always_comb begin
    inc_en    = en_0 && !clr;
    wrap      = inc_en && all_nine;
    count_nxt = inc_en ? count_inc : count_q;
    latch     = (state_q == DEINT) && ch[2] && !clr;
  end

  // phase tracking decoded from the FSM select lines
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ch == 3'b001) state_d = INTEG;
        end
        INTEG: begin
          if (ch == 3'b010)  state_d = DEINT;
          else if (ch[2])    state_d = DONE;
        end
        DEINT: begin
          if (ch[2]) state_d = DONE;
        end
        DONE: begin
          if (ch == 3'b001) state_d = INTEG;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // counter, carry pulse, overrange and result latch
  always_comb begin
    count_d  = clr ? '0 : count_nxt;
    en_3_d   = wrap;
    valid_d  = latch;
    result_d = latch ? count_nxt : result_q;
    if (clr) ovf_d = 1'b0;
    else     ovf_d = ovf_q | (wrap && (state_q == DEINT));
  end

  // all state registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
      en_3_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
      en_3_q   <= en_3_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign en_3   = en_3_q;
  assign count  = count_q;
  assign result = result_q;
  assign valid  = valid_q;
  assign ovf    = ovf_q;

endmodule
